// File: rtl/seq_pkg.sv
// Shared types, opcode decode and per-step strobe tables for the sequencer control-decode stage.
// The tables are pure functions so that the FSM in the top level stays small.
package seq_pkg;

  localparam int N_STEPS = 24;
  localparam int DATA_W  = 8;
  localparam int N_REG   = 13;
  localparam int STEP_W  = 5;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

  typedef enum logic [3:0] {
    A, B, C, D, M1, M2, X, Y, J1, J2, PC, INC, INST
  } reg_idx_e;

  typedef enum logic [3:0] {
    CL_MOV8, CL_SETAB, CL_ALU, CL_LOAD, CL_STORE,
    CL_MOV16, CL_INCXY, CL_GOTO, CL_HALT, CL_UNDEF
  } instr_class_e;

  typedef enum logic [1:0] {
    FETCH, EXEC, HALTED, SYNC
  } fsm_state_e;

  typedef struct packed {
    logic [N_REG-1:0] sel;
    logic [N_REG-1:0] ld;
    logic             mem_rd;
    logic             mem_wr;
    logic [3:0]       abort;
  } strobe_t;

  // Indexed by instr_class_e.
  localparam logic [STEP_W-1:0] CLASS_LEN [10] = '{
    5'd8, 5'd8, 5'd8, 5'd12, 5'd12, 5'd10, 5'd14, 5'd24, 5'd10, 5'd8
  };

  function automatic logic [N_REG-1:0] rbit(reg_idx_e r);
    return N_REG'(1) << r;
  endfunction

  function automatic instr_class_e decode_class(logic [7:0] ir);
    instr_class_e cls;
    casez (ir)
      8'b00??????: cls = CL_MOV8;
      8'b01??????: cls = CL_SETAB;
      8'b1000????: cls = CL_ALU;
      8'b100100??: cls = CL_LOAD;
      8'b100110??: cls = CL_STORE;
      8'b10100???: cls = CL_MOV16;
      8'b10101110: cls = CL_HALT;
      8'b10110000: cls = CL_INCXY;
      8'b11??????: cls = CL_GOTO;
      default:     cls = CL_UNDEF;
    endcase
    return cls;
  endfunction

  // 8-bit register field codes: 0=D 1=A 2=B 3=C 4=M1 5=M2 6=X 7=Y.
  function automatic reg_idx_e reg8(logic [2:0] code);
    reg_idx_e r;
    case (code)
      3'd0:    r = D;
      3'd1:    r = A;
      3'd2:    r = B;
      3'd3:    r = C;
      3'd4:    r = M1;
      3'd5:    r = M2;
      3'd6:    r = X;
      default: r = Y;
    endcase
    return r;
  endfunction

  function automatic logic [N_REG-1:0] pair16(logic [1:0] code);
    logic [N_REG-1:0] m;
    case (code)
      2'd0:    m = rbit(M1) | rbit(M2);
      2'd1:    m = rbit(X) | rbit(Y);
      2'd2:    m = rbit(J1) | rbit(J2);
      default: m = rbit(PC);
    endcase
    return m;
  endfunction

  // Condition bits {sign, carry, zero, not-zero}; an empty mask means unconditional.
  function automatic logic goto_cond(logic [3:0] cnd, logic z, logic s, logic c);
    return (cnd == 4'b0000) | (cnd[3] & s) | (cnd[2] & c) | (cnd[1] & z) | (cnd[0] & ~z);
  endfunction

  function automatic logic [3:0] abort_code(logic [STEP_W-1:0] len);
    logic [3:0] a;
    case (len)
      5'd8:    a = 4'b0001;
      5'd10:   a = 4'b0010;
      5'd12:   a = 4'b0100;
      5'd14:   a = 4'b1000;
      default: a = 4'b0000;
    endcase
    return a;
  endfunction

  function automatic strobe_t fetch_strobes(logic [STEP_W-1:0] step);
    strobe_t s;
    s = '0;
    if (step >= 5'd1 && step <= 5'd4) begin
      s.sel    = rbit(PC);
      s.mem_rd = 1'b1;
      s.ld     = rbit(INC);
    end
    if (step == 5'd3) s.ld = s.ld | rbit(INST);
    if (step == 5'd5 || step == 5'd6) s.sel = rbit(INC);
    if (step == 5'd6) s.ld = rbit(PC);
    return s;
  endfunction

  // Steps 7..23; 8-step classes do their whole transfer on step 7.
  function automatic strobe_t exec_strobes(instr_class_e cls, logic [STEP_W-1:0] step,
                                           logic [5:0] op, logic cond);
    strobe_t          s;
    logic [STEP_W-1:0] len;
    s   = '0;
    len = CLASS_LEN[cls];
    if (len <= LAST_STEP && step == len - 1'b1) s.abort = abort_code(len);
    case (cls)
      CL_MOV8: if (step == 5'd7) begin
        s.sel = rbit(reg8(op[2:0]));
        s.ld  = rbit(reg8(op[5:3]));
      end
      CL_SETAB: if (step == 5'd7) s.ld = rbit(op[5] ? B : A);
      CL_ALU:   if (step == 5'd7) s.ld = rbit(op[3] ? D : A);
      CL_LOAD: if (step >= 5'd8 && step <= 5'd10) begin
        s.sel    = rbit(M1) | rbit(M2);
        s.mem_rd = 1'b1;
        if (step == 5'd10) s.ld = rbit(reg_idx_e'({2'b00, op[1:0]}));
      end
      CL_STORE: if (step >= 5'd8 && step <= 5'd10) begin
        s.sel    = rbit(M1) | rbit(M2) | rbit(reg_idx_e'({2'b00, op[1:0]}));
        s.mem_wr = (step == 5'd9);
      end
      CL_MOV16: if (step == 5'd8 || step == 5'd9) begin
        s.sel = pair16(op[1:0]);
        if (step == 5'd9) s.ld = op[2] ? (rbit(X) | rbit(Y)) : (rbit(M1) | rbit(M2));
      end
      CL_INCXY: begin
        if (step >= 5'd8 && step <= 5'd10) begin
          s.sel = rbit(X) | rbit(Y);
          s.ld  = rbit(INC);
        end
        if (step == 5'd11 || step == 5'd12) s.sel = rbit(INC);
        if (step == 5'd12) s.ld = rbit(X) | rbit(Y);
      end
      CL_GOTO: begin
        // Two address bytes fetched into M1/M2, then M drives the jump target.
        if ((step >= 5'd8 && step <= 5'd10) || (step >= 5'd13 && step <= 5'd15)) begin
          s.sel    = rbit(PC);
          s.mem_rd = 1'b1;
          s.ld     = rbit(INC);
        end
        if (step == 5'd10) s.ld = s.ld | rbit(M1);
        if (step == 5'd15) s.ld = s.ld | rbit(M2);
        if (step == 5'd11 || step == 5'd12) s.sel = rbit(INC);
        if (step == 5'd12) s.ld = rbit(PC);
        if (step >= 5'd16 && step <= 5'd22) s.sel = rbit(M1) | rbit(M2);
        if (step == 5'd21 && cond) s.ld = rbit(PC);
      end
      default: ;
    endcase
    return s;
  endfunction

  // A full 16-bit pair (M, XY, J) may drive the address side alongside one data source.
  function automatic logic sel_legal(logic [N_REG-1:0] sel);
    logic [N_REG-1:0] rest;
    logic [N_REG-1:0] pm, px, pj;
    pm   = rbit(M1) | rbit(M2);
    px   = rbit(X) | rbit(Y);
    pj   = rbit(J1) | rbit(J2);
    rest = sel;
    if ((rest & pm) == pm) rest = rest & ~pm;
    if ((rest & px) == px) rest = rest & ~px;
    if ((rest & pj) == pj) rest = rest & ~pj;
    return $onehot0(rest);
  endfunction

endpackage

// File: rtl/seq_step_checker.sv
// Tracks the step number the sequencer should present next and flags any step that arrives
// out of order; after a mismatch it waits for step 0 before trusting the sequence again.
module seq_step_checker
  import seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              step_valid,
  input  logic [STEP_W-1:0] step,
  input  logic              abort_now,
  output logic              step_err,
  output logic              seq_err
);

  logic [STEP_W-1:0] expected;

  assign step_err = step_valid && (step != expected);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      expected <= '0;
      seq_err  <= 1'b0;
    end else if (step_valid) begin
      if (step_err) begin
        seq_err  <= 1'b1;
        expected <= '0;
      end else if (abort_now || expected == LAST_STEP) begin
        expected <= '0;
      end else begin
        expected <= expected + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sequencer_decoder.sv
// Control-decode stage behind the 24-step sequencer: FETCH/EXEC/HALTED FSM turning step number
// and instruction into registered register/memory strobes and early-abort requests.
module sequencer_decoder
  import seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              step_valid,
  input  logic [STEP_W-1:0] step,
  input  logic [DATA_W-1:0] ir,
  input  logic              flag_z,
  input  logic              flag_s,
  input  logic              flag_c,
  output logic [N_REG-1:0]  sel,
  output logic [N_REG-1:0]  ld,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [2:0]        alu_fn,
  output logic [3:0]        abort,
  output logic              halted,
  output logic              seq_err
);

  fsm_state_e        state, state_nxt;
  instr_class_e      cls_now, cls_lat;
  logic [DATA_W-1:0] ir_lat;
  logic [2:0]        flags_lat;
  logic              latch_p0;
  logic              step_err;
  strobe_t           str_p0, str_p1;
  logic              halted_p1;

  assign cls_now = decode_class(ir);

  seq_step_checker u_chk (
    .clock      (clock),
    .reset      (reset),
    .step_valid (step_valid),
    .step       (step),
    .abort_now  (|str_p0.abort),
    .step_err   (step_err),
    .seq_err    (seq_err)
  );

  // p0: decode the presented step
  always_comb begin
    state_nxt = state;
    str_p0    = '0;
    latch_p0  = 1'b0;
    if (step_valid && state != HALTED) begin
      if (step_err) begin
        state_nxt = SYNC;
      end else if (state == SYNC) begin
        // while resyncing only step 0 can match, and step 0 carries no strobes
        state_nxt = FETCH;
      end else if (state == FETCH || step == '0) begin
        state_nxt = FETCH;
        str_p0    = fetch_strobes(step);
        if (step == 5'd7) begin
          str_p0    = exec_strobes(cls_now, step, ir[5:0],
                                   goto_cond(ir[4:1], flag_z, flag_s, flag_c));
          latch_p0  = 1'b1;
          state_nxt = EXEC;
        end
      end else begin
        str_p0 = exec_strobes(cls_lat, step, ir_lat[5:0],
                              goto_cond(ir_lat[4:1], flags_lat[2], flags_lat[1], flags_lat[0]));
        if (cls_lat == CL_HALT && step == 5'd9) state_nxt = HALTED;
      end
    end
  end

  // p1: state and output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      ir_lat    <= '0;
      flags_lat <= '0;
      cls_lat   <= CL_MOV8;
      str_p1    <= '0;
      halted_p1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      str_p1    <= str_p0;
      halted_p1 <= (state == HALTED);
      if (latch_p0) begin
        ir_lat    <= ir;
        flags_lat <= {flag_z, flag_s, flag_c};
        cls_lat   <= cls_now;
      end
    end
  end

  assign sel    = str_p1.sel;
  assign ld     = str_p1.ld;
  assign mem_rd = str_p1.mem_rd;
  assign mem_wr = str_p1.mem_wr;
  assign abort  = str_p1.abort;
  assign alu_fn = ir_lat[2:0];
  assign halted = halted_p1;

  sel_onehot_a: assert property (@(posedge clock) disable iff (reset) sel_legal(sel));

endmodule

// File: tb/tb_sequencer_decoder.sv
// Directed bench for sequencer_decoder: steps the sequencer by hand through several
// instructions and compares every registered output against hand-derived values.
module tb_sequencer_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        step_valid;
  logic [4:0]  step;
  logic [7:0]  ir;
  logic        flag_z, flag_s, flag_c;
  logic [12:0] sel, ld;
  logic        mem_rd, mem_wr;
  logic [2:0]  alu_fn;
  logic [3:0]  abort;
  logic        halted, seq_err;

  int checks = 0;
  int errors = 0;

  localparam int RA = 0, RB = 1, RM1 = 4, RM2 = 5, RX = 6, RY = 7;
  localparam int RPC = 10, RINC = 11, RINST = 12;

  sequencer_decoder dut (
    .clock      (clock),
    .reset      (reset),
    .step_valid (step_valid),
    .step       (step),
    .ir         (ir),
    .flag_z     (flag_z),
    .flag_s     (flag_s),
    .flag_c     (flag_c),
    .sel        (sel),
    .ld         (ld),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .alu_fn     (alu_fn),
    .abort      (abort),
    .halted     (halted),
    .seq_err    (seq_err)
  );

  always #5 clock = ~clock;

  function automatic logic [12:0] bv(int i);
    return 13'(1) << i;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(string tag, logic [12:0] es, logic [12:0] el, logic er, logic ew,
                      logic [3:0] ea);
    check($sformatf("%s.sel", tag), 32'(sel), 32'(es));
    check($sformatf("%s.ld", tag), 32'(ld), 32'(el));
    check($sformatf("%s.mem_rd", tag), 32'(mem_rd), 32'(er));
    check($sformatf("%s.mem_wr", tag), 32'(mem_wr), 32'(ew));
    check($sformatf("%s.abort", tag), 32'(abort), 32'(ea));
  endtask

  task automatic tick(logic v, int s);
    step_valid = v;
    step       = 5'(s);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_chk(string tag, int s);
    logic [12:0] es, el;
    logic        er;
    es = (s >= 1 && s <= 4) ? bv(RPC) : ((s == 5 || s == 6) ? bv(RINC) : 13'd0);
    el = ((s >= 1 && s <= 4) ? bv(RINC) : 13'd0) | ((s == 3) ? bv(RINST) : 13'd0)
       | ((s == 6) ? bv(RPC) : 13'd0);
    er = (s >= 1 && s <= 4);
    outs($sformatf("%s.f%0d", tag, s), es, el, er, 1'b0, 4'b0000);
  endtask

  task automatic run_fetch(string tag);
    for (int s = 0; s < 7; s++) begin
      tick(1'b1, s);
      fetch_chk(tag, s);
    end
  endtask

  initial begin
    reset = 1'b1; step_valid = 1'b0; step = '0; ir = '0;
    flag_z = 1'b0; flag_s = 1'b0; flag_c = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    outs("reset", 13'd0, 13'd0, 1'b0, 1'b0, 4'b0000);
    check("reset.alu_fn", 32'(alu_fn), 32'd0);
    check("reset.halted", 32'(halted), 32'd0);
    check("reset.seq_err", 32'(seq_err), 32'd0);
    reset = 1'b0;

    // MOV8 B->A
    ir = 8'h0A;
    run_fetch("mov8");
    tick(1'b1, 7);
    outs("mov8.s7", bv(RB), bv(RA), 1'b0, 1'b0, 4'b0001);
    check("mov8.alu_fn", 32'(alu_fn), 32'd2);

    // LOAD A from M
    ir = 8'h90;
    run_fetch("load");
    tick(1'b1, 7);
    outs("load.s7", 13'd0, 13'd0, 1'b0, 1'b0, 4'b0000);
    for (int s = 8; s <= 10; s++) begin
      tick(1'b1, s);
      outs($sformatf("load.s%0d", s), bv(RM1) | bv(RM2), (s == 10) ? bv(RA) : 13'd0,
           1'b1, 1'b0, 4'b0000);
    end
    tick(1'b1, 11);
    outs("load.s11", 13'd0, 13'd0, 1'b0, 1'b0, 4'b0100);

    // GOTO on zero, condition false then true
    for (int z = 0; z < 2; z++) begin
      ir = 8'hC4;
      flag_z = z[0];
      for (int s = 0; s < 24; s++) begin
        tick(1'b1, s);
        if (s < 7) fetch_chk($sformatf("goto%0d", z), s);
        if (s == 8) check("goto.s8.sel", 32'(sel), 32'(bv(RPC)));
        check($sformatf("goto%0d.s%0d.ldpc", z, s), 32'(ld[RPC]),
              32'((s == 6) || (s == 12) || (z == 1 && s == 21)));
        check($sformatf("goto%0d.s%0d.abort", z, s), 32'(abort), 32'd0);
      end
    end
    flag_z = 1'b0;

    // HALT
    ir = 8'hAE;
    run_fetch("halt");
    tick(1'b1, 7);
    outs("halt.s7", 13'd0, 13'd0, 1'b0, 1'b0, 4'b0000);
    tick(1'b1, 8);
    outs("halt.s8", 13'd0, 13'd0, 1'b0, 1'b0, 4'b0000);
    tick(1'b1, 9);
    outs("halt.s9", 13'd0, 13'd0, 1'b0, 1'b0, 4'b0010);
    check("halt.s9.halted", 32'(halted), 32'd0);
    for (int s = 0; s < 4; s++) begin
      tick(1'b1, s);
      outs($sformatf("halted.s%0d", s), 13'd0, 13'd0, 1'b0, 1'b0, 4'b0000);
      check($sformatf("halted.s%0d.flag", s), 32'(halted), 32'd1);
    end
    #2 reset = 1'b1;
    #1 check("halt.reset.halted", 32'(halted), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Step 5 followed by step 7
    ir = 8'h0A;
    for (int s = 0; s < 6; s++) begin
      tick(1'b1, s);
      fetch_chk("seq", s);
    end
    check("seq.pre.seq_err", 32'(seq_err), 32'd0);
    tick(1'b1, 7);
    outs("seq.bad7", 13'd0, 13'd0, 1'b0, 1'b0, 4'b0000);
    check("seq.bad7.seq_err", 32'(seq_err), 32'd1);
    tick(1'b1, 3);
    outs("seq.bad3", 13'd0, 13'd0, 1'b0, 1'b0, 4'b0000);
    tick(1'b1, 0);
    outs("seq.s0", 13'd0, 13'd0, 1'b0, 1'b0, 4'b0000);
    tick(1'b1, 1);
    fetch_chk("seq.resync", 1);
    tick(1'b0, 2);
    outs("seq.invalid", 13'd0, 13'd0, 1'b0, 1'b0, 4'b0000);
    for (int s = 2; s < 7; s++) begin
      tick(1'b1, s);
      fetch_chk("seq.resync", s);
    end
    tick(1'b1, 7);
    outs("seq.s7", bv(RB), bv(RA), 1'b0, 1'b0, 4'b0001);
    check("seq.sticky", 32'(seq_err), 32'd1);

    // INCXY with reset at step 12
    ir = 8'hB0;
    run_fetch("incxy");
    tick(1'b1, 7);
    outs("incxy.s7", 13'd0, 13'd0, 1'b0, 1'b0, 4'b0000);
    for (int s = 8; s <= 10; s++) begin
      tick(1'b1, s);
      outs($sformatf("incxy.s%0d", s), bv(RX) | bv(RY), bv(RINC), 1'b0, 1'b0, 4'b0000);
    end
    tick(1'b1, 11);
    outs("incxy.s11", bv(RINC), 13'd0, 1'b0, 1'b0, 4'b0000);
    tick(1'b1, 12);
    outs("incxy.s12", bv(RINC), bv(RX) | bv(RY), 1'b0, 1'b0, 4'b0000);
    #2 reset = 1'b1;
    #1;
    outs("async", 13'd0, 13'd0, 1'b0, 1'b0, 4'b0000);
    check("async.seq_err", 32'(seq_err), 32'd0);
    check("async.halted", 32'(halted), 32'd0);
    check("async.alu_fn", 32'(alu_fn), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    ir = 8'h0A;
    run_fetch("post");
    tick(1'b1, 7);
    outs("post.s7", bv(RB), bv(RA), 1'b0, 1'b0, 4'b0001);
    check("post.seq_err", 32'(seq_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
